// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch and load/store requests into little-endian byte-wide RAM transactions.
// Optional MEMCTRL_IO_STALL_EN holds IO-region store bytes while io_buffer_full is set.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [2:0]  n_q, n_d, cnt_q, cnt_d;
  logic        io_q, io_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic [31:0] if_inst_q, if_inst_d, ls_rdata_q, ls_rdata_d;
  logic [2:0]  nxt, ls_n;
  logic [1:0]  k;
  logic [31:0] wb;
  logic        stall, acc_stall;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign if_done  = if_done_q;
  assign if_inst  = if_inst_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    io_d       = io_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_inst_d  = if_inst_q;
    ls_rdata_d = ls_rdata_q;
    nxt        = cnt_q + 3'd1;
    k          = cnt_q[1:0] - 2'd1;
    wb         = data_q;
    wb[{k, 3'b000} +: 8] = mem_din;
    ls_n       = ls_size == 2'b00 ? 3'd1 : ls_size == 2'b01 ? 3'd2 : 3'd4;
`ifdef MEMCTRL_IO_STALL_EN
    stall      = io_q & io_buffer_full;
    acc_stall  = (ls_addr >= IO_BASE) & io_buffer_full;
`else
    stall      = io_q & io_buffer_full & 1'b0;
    acc_stall  = io_buffer_full & 1'b0;
`endif
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          // the registered dones block acceptance, giving the bubble after every completion
          if (!clear_in && !if_done_q && !ls_done_q) begin
            if (ls_req) begin
              addr_d  = ls_addr;
              wdata_d = ls_wdata;
              io_d    = ls_addr >= IO_BASE;
              n_d     = ls_n;
              cnt_d   = 3'd0;
              data_d  = 32'd0;
              mem_a_d = ls_addr;
              if (ls_wr) begin
                state_d    = STORE;
                mem_wr_d   = !acc_stall;
                mem_dout_d = ls_wdata[7:0];
              end else begin
                state_d = LOAD;
              end
            end else if (if_req) begin
              addr_d  = if_addr;
              n_d     = 3'd4;
              cnt_d   = 3'd0;
              data_d  = 32'd0;
              mem_a_d = if_addr;
              state_d = FETCH;
            end
          end
        end
        FETCH, LOAD: begin
          if (clear_in) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            mem_a_d = 32'd0;
          end else begin
            // byte cnt_q-1 arrives now, one cycle behind its address
            cnt_d  = nxt;
            data_d = cnt_q != 3'd0 ? wb : data_q;
            if (nxt < n_q) mem_a_d = addr_q + {29'd0, nxt};
            if (cnt_q == n_q) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
              mem_a_d = 32'd0;
              if (state_q == FETCH) begin
                if_done_d = 1'b1;
                if_inst_d = wb;
              end else begin
                ls_done_d  = 1'b1;
                ls_rdata_d = wb;
              end
            end
          end
        end
        STORE: begin
          // mem_wr_q low means byte cnt_q is still waiting for the IO buffer
          if (mem_wr_q) begin
            if (nxt == n_q) begin
              state_d   = IDLE;
              cnt_d     = 3'd0;
              mem_wr_d  = 1'b0;
              mem_a_d   = 32'd0;
              ls_done_d = 1'b1;
            end else begin
              cnt_d      = nxt;
              mem_a_d    = addr_q + {29'd0, nxt};
              mem_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
              mem_wr_d   = !stall;
            end
          end else if (!stall) begin
            mem_wr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if_done_d = if_done_q;
      ls_done_d = ls_done_q;
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      data_q     <= 32'd0;
      n_q        <= 3'd0;
      cnt_q      <= 3'd0;
      io_q       <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_inst_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      io_q       <= io_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_inst_q  <= if_inst_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end
endmodule
